// File: rtl/snapshot_scheduler.sv
// Checkpoint-slot sequencer for the speculative register snapshot bank.
// Optional statistics counters are enabled by defining SNAPSHOT_SCHED_STATS_EN.
module snapshot_scheduler #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              take_req,
    input  logic              wb_busy,
    input  logic              resolve_valid,
    input  logic              resolve_mispredict,
    output logic              take_ack,
    output logic              take_stall,
    output logic              snap_we,
    output logic [SLOT_W-1:0] snap_slot,
    output logic              restore_we,
    output logic [SLOT_W-1:0] restore_slot,
    output logic [SLOT_W:0]   occupancy,
    output logic              resolve_err
`ifdef SNAPSHOT_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_snaps,
    output logic [31:0]       stat_restores,
    output logic [31:0]       stat_full_stalls
`endif
);

    typedef enum logic [1:0] {IDLE, DRAIN, CAPTURE, RESTORE} state_t;

    localparam logic [SLOT_W:0] FULL = (SLOT_W+1)'(NUM_SLOTS);

    state_t            state, state_nx;
    logic [SLOT_W-1:0] head, head_nx, tail, tail_nx;
    logic [SLOT_W:0]   occ_nx;
    logic              full, mispredict, good_resolve;

    assign full         = (occupancy == FULL);
    assign mispredict   = resolve_valid && resolve_mispredict && (occupancy != '0);
    assign good_resolve = resolve_valid && !resolve_mispredict && (occupancy != '0);
    assign take_stall   = (state != IDLE) || full;
    assign snap_slot    = tail;
    assign restore_slot = head;

    always_comb begin
        state_nx   = state;
        snap_we    = 1'b0;
        take_ack   = 1'b0;
        restore_we = 1'b0;
        case (state)
            IDLE: begin
                if (mispredict)
                    state_nx = RESTORE;
                else if (take_req && !full)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (mispredict)
                    state_nx = RESTORE;
                else if (!wb_busy)
                    state_nx = CAPTURE;
            end
            CAPTURE: begin
                // A mispredict in the capture cycle kills the capture outright
                if (mispredict) begin
                    state_nx = RESTORE;
                end else begin
                    snap_we  = 1'b1;
                    take_ack = 1'b1;
                    state_nx = IDLE;
                end
            end
            RESTORE: begin
                restore_we = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        head_nx = head;
        tail_nx = tail;
        occ_nx  = occupancy + {{SLOT_W{1'b0}}, snap_we} - {{SLOT_W{1'b0}}, good_resolve};
        if (good_resolve)
            head_nx = head + SLOT_W'(1);
        if (snap_we)
            tail_nx = tail + SLOT_W'(1);
        // Restore discards every live checkpoint, so the ring restarts at slot 0
        if (state == RESTORE) begin
            head_nx = '0;
            tail_nx = '0;
            occ_nx  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            occupancy   <= '0;
            resolve_err <= 1'b0;
        end else begin
            state     <= state_nx;
            head      <= head_nx;
            tail      <= tail_nx;
            occupancy <= occ_nx;
            if (resolve_valid && occupancy == '0)
                resolve_err <= 1'b1;
        end
    end

`ifdef SNAPSHOT_SCHED_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_snaps       <= '0;
            stat_restores    <= '0;
            stat_full_stalls <= '0;
        end else begin
            if (snap_we)
                stat_snaps <= sat_inc(stat_snaps);
            if (restore_we)
                stat_restores <= sat_inc(stat_restores);
            if (take_req && full)
                stat_full_stalls <= sat_inc(stat_full_stalls);
        end
    end
`endif

endmodule

// File: tb/tb_snapshot_scheduler.sv
// Scoreboard bench for snapshot_scheduler: a queue-based checkpoint model
// predicts each cycle's outputs, a negedge monitor compares them.
module tb_snapshot_scheduler;

    localparam int N  = 2;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          take_req = 1'b0, wb_busy = 1'b0;
    logic          resolve_valid = 1'b0, resolve_mispredict = 1'b0;
    logic          take_ack, take_stall, snap_we, restore_we, resolve_err;
    logic [SW-1:0] snap_slot, restore_slot;
    logic [SW:0]   occupancy;
`ifdef SNAPSHOT_SCHED_STATS_EN
    logic [31:0]   stat_snaps, stat_restores, stat_full_stalls;
`endif

    snapshot_scheduler #(.NUM_SLOTS(N)) dut (
        .clk(clk), .rst(rst), .take_req(take_req), .wb_busy(wb_busy),
        .resolve_valid(resolve_valid), .resolve_mispredict(resolve_mispredict),
        .take_ack(take_ack), .take_stall(take_stall), .snap_we(snap_we),
        .snap_slot(snap_slot), .restore_we(restore_we), .restore_slot(restore_slot),
        .occupancy(occupancy), .resolve_err(resolve_err)
`ifdef SNAPSHOT_SCHED_STATS_EN
        , .stat_snaps(stat_snaps), .stat_restores(stat_restores),
        .stat_full_stalls(stat_full_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit snap;
        bit rest;
        bit stall;
        bit err;
        int occ;
        int sslot;
        int rslot;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: live checkpoints as an ordered list of slot numbers
    int   live[$];
    int   next_slot;
    bit   m_drain, m_cap, m_rest, m_err;
    int   m_rslot;
    bit   last_snap, last_rest;
    int   m_snaps, m_restores, m_full;

    task automatic model_reset();
        live.delete();
        next_slot = 0;
        m_drain = 0; m_cap = 0; m_rest = 0; m_err = 0;
        m_rslot = 0;
        m_snaps = 0; m_restores = 0; m_full = 0;
    endtask

    task automatic cycle(input bit treq, input bit wb, input bit rv, input bit rm,
                         input bit r = 1'b0);
        exp_t e;
        int   occ;
        bit   mis;
        @(posedge clk);
        #1;
        rst = r; take_req = treq; wb_busy = wb;
        resolve_valid = rv; resolve_mispredict = rm;
        e = '{default: 0};
        last_snap = 0; last_rest = 0;
        if (r) begin
            model_reset();
            q.push_back(e);
            return;
        end
        occ     = live.size();
        mis     = rv && rm && occ > 0;
        e.snap  = m_cap && !mis;
        e.sslot = next_slot;
        e.rest  = m_rest;
        e.rslot = m_rslot;
        e.stall = m_drain || m_cap || m_rest || occ == N;
        e.occ   = occ;
        e.err   = m_err;
        q.push_back(e);
        last_snap = e.snap; last_rest = e.rest;
        if (e.snap) m_snaps++;
        if (e.rest) m_restores++;
        if (treq && occ == N) m_full++;
        if (rv && occ == 0) m_err = 1;
        if (m_rest) begin
            live.delete();
            next_slot = 0;
            m_rest = 0;
        end else if (mis) begin
            m_rest = 1; m_rslot = live[0];
            m_drain = 0; m_cap = 0;
        end else begin
            if (rv && occ > 0) void'(live.pop_front());
            if (m_cap) begin
                live.push_back(next_slot);
                next_slot = (next_slot + 1) % N;
                m_cap = 0;
            end else if (m_drain) begin
                if (!wb) begin m_drain = 0; m_cap = 1; end
            end else if (treq && occ < N) begin
                m_drain = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("snap_we", int'(snap_we), int'(e.snap));
            chk("take_ack", int'(take_ack), int'(e.snap));
            chk("restore_we", int'(restore_we), int'(e.rest));
            chk("take_stall", int'(take_stall), int'(e.stall));
            chk("occupancy", int'(occupancy), e.occ);
            chk("resolve_err", int'(resolve_err), int'(e.err));
            if (e.snap) chk("snap_slot", int'(snap_slot), e.sslot);
            if (e.rest) chk("restore_slot", int'(restore_slot), e.rslot);
        end
    end

    initial begin
        bit treq_h;
        model_reset();
        // 1: reset then minimum-latency take
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // 2: take held off by three cycles of writeback
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // 3: full, take stalled, resolve in full cycle, take wraps to slot 0
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // 4: mispredict at full occupancy
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // 5: mispredict lands on the capture cycle
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // 6: resolve with nothing live, then reset in the middle of a drain
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0, 1);
        cycle(0, 0, 0, 0);
        // Randomised traffic; take_req is held until the model sees the capture
        treq_h = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rv, rm, wb, r;
            if (!treq_h && $urandom_range(0, 2) == 0) treq_h = 1;
            wb = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 4) == 0);
            rm = rv && ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 199) == 0);
            cycle(treq_h, wb, rv, rm, r);
            if (last_snap || last_rest || r) treq_h = 0;
        end
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
`ifdef SNAPSHOT_SCHED_STATS_EN
        chk("stat_snaps", int'(stat_snaps), m_snaps);
        chk("stat_restores", int'(stat_restores), m_restores);
        chk("stat_full_stalls", int'(stat_full_stalls), m_full);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
